// File: rtl/dm_responder.sv
// dm_responder: data-memory request responder in front of a fixed-latency SRAM.
// Issues one byte-lane-steered SRAM command per CPU request, stalls the CPU for
// LAT+1 cycles, and returns the extended load word in the DONE cycle.
module dm_responder #(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 14
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_ceb,
  input  logic          i_req_web,
  input  logic [31:0]   i_req_addr,
  input  logic [31:0]   i_req_wdata,
  input  logic [1:0]    i_req_store,
  input  logic [2:0]    i_req_load,
  output logic          o_stall,
  output logic [31:0]   o_rdata,
  output logic          o_sram_ceb,
  output logic [3:0]    o_sram_web,
  output logic [AW-1:0] o_sram_a,
  output logic [31:0]   o_sram_di,
  input  logic [31:0]   i_sram_do
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] CntInit = 4'(LAT - 1);

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_web;
  logic [1:0]  r_lane;
  logic [2:0]  r_load;
  logic        w_start;
  logic        w_last;
  logic        w_stall;
  logic [3:0]  w_web_wr;
  logic [31:0] w_di_wr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic        w_unused;

  // Upper address bits fall outside the SRAM word range.
  assign w_unused = ^i_req_addr[31:AW+2];

  assign w_start = (r_state == StIdle) && !i_req_ceb;
  assign w_last  = (r_state == StBusy) && (r_cnt == 4'd0);

  // State and latency counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic; the counter stops at zero
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StIdle: begin
        if (!i_req_ceb) begin
          w_state_nxt = StBusy;
          w_cnt_nxt   = CntInit;
        end
      end
      StBusy: begin
        if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
        else               w_state_nxt = StDone;
      end
      // The CPU still presents the retiring request here, so it is ignored.
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Stall output; forced low while reset is asserted
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      StIdle:  w_stall = !i_req_ceb;
      StBusy:  w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
    o_stall = i_rst_n && w_stall;
  end

  // Store lane enables and replicated write data; store type 00 acts as SW
  always_comb begin
    w_web_wr = 4'b0000;
    w_di_wr  = i_req_wdata;
    case (i_req_store)
      2'b10: begin
        w_web_wr = i_req_addr[1] ? 4'b0011 : 4'b1100;
        w_di_wr  = {2{i_req_wdata[15:0]}};
      end
      2'b11: begin
        w_web_wr = ~(4'b0001 << i_req_addr[1:0]);
        w_di_wr  = {4{i_req_wdata[7:0]}};
      end
      default: begin
        w_web_wr = 4'b0000;
        w_di_wr  = i_req_wdata;
      end
    endcase
  end

  // Load extraction from the captured lane and load type
  always_comb begin
    w_byte = i_sram_do[8*r_lane +: 8];
    w_half = r_lane[1] ? i_sram_do[31:16] : i_sram_do[15:0];
    case (r_load)
      3'b001:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b101:  w_ext = {24'd0, w_byte};
      3'b010:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {16'd0, w_half};
      default: w_ext = i_sram_do;
    endcase
  end

  // Request capture, SRAM command drive and load result register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_web      <= 1'b1;
      r_lane     <= 2'd0;
      r_load     <= 3'd0;
      o_sram_ceb <= 1'b1;
      o_sram_web <= 4'b1111;
      o_sram_a   <= '0;
      o_sram_di  <= 32'd0;
      o_rdata    <= 32'd0;
    end else begin
      if (w_start) begin
        r_web      <= i_req_web;
        r_lane     <= i_req_addr[1:0];
        r_load     <= i_req_load;
        o_sram_ceb <= 1'b0;
        o_sram_a   <= i_req_addr[AW+1:2];
        if (!i_req_web) begin
          o_sram_web <= w_web_wr;
          o_sram_di  <= w_di_wr;
        end else begin
          o_sram_web <= 4'b1111;
        end
      end else begin
        o_sram_ceb <= 1'b1;
      end
      if (w_last && r_web) o_rdata <= w_ext;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances at LAT=2, LAT=1 and LAT=15.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_ceb;
  logic        req_web;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_store;
  logic [2:0]  req_load;
  logic [31:0] sram_do;

  logic [2:0]  stall;
  logic [31:0] rdata   [3];
  logic [2:0]  sram_ceb;
  logic [3:0]  sram_web[3];
  logic [13:0] sram_a  [3];
  logic [31:0] sram_di [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_responder #(.LAT(2), .AW(14)) u_dut_l2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_ceb(req_ceb[0]), .i_req_web(req_web),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_store(req_store),
    .i_req_load(req_load), .o_stall(stall[0]), .o_rdata(rdata[0]),
    .o_sram_ceb(sram_ceb[0]), .o_sram_web(sram_web[0]), .o_sram_a(sram_a[0]),
    .o_sram_di(sram_di[0]), .i_sram_do(sram_do)
  );

  dm_responder #(.LAT(1), .AW(14)) u_dut_l1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_ceb(req_ceb[1]), .i_req_web(req_web),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_store(req_store),
    .i_req_load(req_load), .o_stall(stall[1]), .o_rdata(rdata[1]),
    .o_sram_ceb(sram_ceb[1]), .o_sram_web(sram_web[1]), .o_sram_a(sram_a[1]),
    .o_sram_di(sram_di[1]), .i_sram_do(sram_do)
  );

  dm_responder #(.LAT(15), .AW(14)) u_dut_l15 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_ceb(req_ceb[2]), .i_req_web(req_web),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_store(req_store),
    .i_req_load(req_load), .o_stall(stall[2]), .o_rdata(rdata[2]),
    .o_sram_ceb(sram_ceb[2]), .o_sram_web(sram_web[2]), .o_sram_a(sram_a[2]),
    .o_sram_di(sram_di[2]), .i_sram_do(sram_do)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request on instance d; returns stall/command statistics and the DONE-cycle rdata.
  task automatic access(input int d, input logic web, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] st, input logic [2:0] ld,
                        output int n_stall, output int n_ceb, output int ceb_first,
                        output logic [13:0] a_cmd, output logic [3:0] web_cmd,
                        output logic [31:0] di_cmd, output logic [31:0] rd_done);
    bit done = 0;
    n_stall = 0; n_ceb = 0; ceb_first = -1;
    a_cmd = '0; web_cmd = '0; di_cmd = '0; rd_done = '0;
    @(negedge clk);
    req_web = web; req_addr = addr; req_wdata = wdata; req_store = st; req_load = ld;
    req_ceb[d] = 1'b0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (sram_ceb[d] == 1'b0) begin
        n_ceb++;
        if (ceb_first < 0) ceb_first = c;
        a_cmd = sram_a[d]; web_cmd = sram_web[d]; di_cmd = sram_di[d];
      end
      if (stall[d]) n_stall++;
      else if (c > 0) begin
        rd_done = rdata[d];
        done = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!done) check("access_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_ceb[d] = 1'b1;
  endtask

  int          ns, nc, cf;
  logic [13:0] a;
  logic [3:0]  w;
  logic [31:0] di, rd;
  logic [5:0]  pat;
  int          pulses;

  logic [2:0]  ld_tab  [4] = '{3'b001, 3'b101, 3'b010, 3'b100};
  logic [31:0] adr_tab [4] = '{32'h0000_0010, 32'h0000_0010, 32'h0000_0012, 32'h0000_0012};
  logic [31:0] exp_tab [4] = '{32'hFFFF_FF82, 32'h0000_0082, 32'hFFFF_80F1, 32'h0000_80F1};
  string       nm_tab  [4] = '{"lb", "lbu", "lh", "lhu"};

  initial begin
    rst_n = 1'b0; req_ceb = 3'b111; req_web = 1'b1; req_addr = '0; req_wdata = '0;
    req_store = 2'b00; req_load = 3'b000; sram_do = '0;
    #12;
    check("rst_stall", {31'd0, stall[0]}, 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_ceb", {31'd0, sram_ceb[0]}, 32'd1);
    check("rst_web", {28'd0, sram_web[0]}, 32'hF);
    check("rst_a", {18'd0, sram_a[0]}, 32'd0);
    check("rst_di", sram_di[0], 32'd0);
    req_ceb[0] = 1'b0;
    #1;
    check("rst_stall_req", {31'd0, stall[0]}, 32'd0);
    req_ceb[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // LW, LAT=2
    sram_do = 32'hDEAD_BEEF;
    access(0, 1'b1, 32'h0000_0008, 32'd0, 2'b00, 3'b011, ns, nc, cf, a, w, di, rd);
    check("lw_stall_cycles", ns, 32'd3);
    check("lw_ceb_pulses", nc, 32'd1);
    check("lw_ceb_cycle", cf, 32'd1);
    check("lw_addr", {18'd0, a}, 32'd2);
    check("lw_web", {28'd0, w}, 32'hF);
    check("lw_rdata", rd, 32'hDEAD_BEEF);

    // Sub-word loads
    sram_do = 32'h80F1_7F82;
    for (int i = 0; i < 4; i++) begin
      access(0, 1'b1, adr_tab[i], 32'd0, 2'b00, ld_tab[i], ns, nc, cf, a, w, di, rd);
      check(nm_tab[i], rd, exp_tab[i]);
      check({nm_tab[i], "_hold"}, rdata[0], exp_tab[i]);
    end

    // SB and SH at 0x102
    access(0, 1'b0, 32'h0000_0102, 32'h1234_56AB, 2'b11, 3'b000, ns, nc, cf, a, w, di, rd);
    check("sb_web", {28'd0, w}, 32'hB);
    check("sb_di", di, 32'hABAB_ABAB);
    check("sb_addr", {18'd0, a}, 32'h40);
    check("sb_stall_cycles", ns, 32'd3);
    check("sb_rdata_kept", rdata[0], 32'h0000_80F1);
    access(0, 1'b0, 32'h0000_0102, 32'h1234_56AB, 2'b10, 3'b000, ns, nc, cf, a, w, di, rd);
    check("sh_web", {28'd0, w}, 32'h3);
    check("sh_di", di, 32'h56AB_56AB);
    check("sh_rdata_kept", rdata[0], 32'h0000_80F1);

    // Store type 00 behaves as SW; a following read keeps sram_di
    access(0, 1'b0, 32'h0000_0004, 32'hCAFE_F00D, 2'b00, 3'b000, ns, nc, cf, a, w, di, rd);
    check("sw00_web", {28'd0, w}, 32'h0);
    check("sw00_di", di, 32'hCAFE_F00D);
    sram_do = 32'h0BAD_F00D;
    access(0, 1'b1, 32'h0000_0004, 32'd0, 2'b00, 3'b000, ns, nc, cf, a, w, di, rd);
    check("rd_di_hold", di, 32'hCAFE_F00D);
    check("rd_web", {28'd0, w}, 32'hF);
    check("ld000_rdata", rd, 32'h0BAD_F00D);

    // Back-to-back LW then SW, LAT=1
    sram_do = 32'h5555_AAAA;
    pat = '0; pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_web = 1'b1; req_addr = 32'h20; req_load = 3'b011; req_store = 2'b00;
        req_ceb[1] = 1'b0;
      end
      if (c == 3) begin
        req_web = 1'b0; req_addr = 32'h24; req_wdata = 32'h0102_0304; req_store = 2'b01;
      end
      #1;
      pat[5-c] = stall[1];
      if (sram_ceb[1] == 1'b0) pulses++;
      if (c == 4) check("b2b_sw_web", {28'd0, sram_web[1]}, 32'h0);
    end
    @(posedge clk);
    #1;
    req_ceb[1] = 1'b1;
    check("b2b_stall_pattern", {26'd0, pat}, 32'b110110);
    check("b2b_ceb_pulses", pulses, 32'd2);
    check("b2b_rdata", rdata[1], 32'h5555_AAAA);

    // LAT=15
    sram_do = 32'h1357_2468;
    access(2, 1'b1, 32'h0000_0040, 32'd0, 2'b00, 3'b011, ns, nc, cf, a, w, di, rd);
    check("l15_stall_cycles", ns, 32'd16);
    check("l15_ceb_pulses", nc, 32'd1);
    check("l15_rdata", rd, 32'h1357_2468);

    // Reset asserted mid-BUSY with the request held
    sram_do = 32'h1111_1111;
    @(negedge clk);
    req_web = 1'b1; req_addr = 32'h8; req_load = 3'b011; req_ceb[0] = 1'b0;
    @(posedge clk);
    #2;
    check("mid_busy_stall", {31'd0, stall[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, stall[0]}, 32'd0);
    check("mid_rst_ceb", {31'd0, sram_ceb[0]}, 32'd1);
    check("mid_rst_web", {28'd0, sram_web[0]}, 32'hF);
    check("mid_rst_rdata", rdata[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("restart_stall", {31'd0, stall[0]}, 32'd1);
    ns = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (!stall[0]) break;
      ns++;
    end
    @(posedge clk);
    #1;
    req_ceb[0] = 1'b1;
    check("restart_stall_cycles", ns, 32'd3);
    check("restart_rdata", rdata[0], 32'h1111_1111);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
